tree_cmd_driver: RTL and testbench

//  Hardware initiator for the Tree key store. Takes FIND/INSERT/CLEAR commands

---
 rtl/tree_drv_pkg.sv | 29 ++
 rtl/tree_cmd_driver.sv | 174 +++++++++++++++++
 tb/tb_tree_cmd_driver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tree_drv_pkg.sv
// Shared op/status codes and FSM state encoding for the Tree command driver.
package tree_drv_pkg;

    localparam int unsigned KEY_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        OP_FIND   = 2'b00,
        OP_INSERT = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK    = 2'b00,
        ST_FULL  = 2'b01,
        ST_EMPTY = 2'b10,
        ST_BAD   = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_GAP,
        S_PGAP
    } state_e;

endpackage

// File: rtl/tree_cmd_driver.sv
// Drives Tree k0/k1/sw pulses from a FIND/INSERT/CLEAR command stream, one response per command.
// Define TREE_DRV_DUP_CHECK_EN to probe with a FIND before each INSERT into a non-empty Tree.
module tree_cmd_driver
    import tree_drv_pkg::*;
#(
    parameter int unsigned KEY_W    = KEY_W_DEFAULT,
    parameter int unsigned RESP_LAT = 1,
    parameter int unsigned GAP      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [KEY_W-1:0] cmd_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_status,
    output logic             rsp_found,
    output logic [KEY_W-1:0] rsp_key,
    output logic [2:0]       rsp_count,
    output logic             k0,
    output logic             k1,
    output logic [KEY_W-1:0] sw,
    input  logic [7:0]       led,
    input  logic             buf_full,
    input  logic             buf_empty,
    input  logic [2:0]       tree_counter
);

    localparam int unsigned CNT_MAX = (RESP_LAT > GAP) ? RESP_LAT : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] sw_q, sw_d;
    logic             probe_q, probe_d;
    status_e          status_q, status_d;
    logic             found_q, found_d;
    logic [KEY_W-1:0] rkey_q, rkey_d;
    logic [2:0]       count_q, count_d;

    op_e  cmd_op_e;
    logic unused_led;

    assign cmd_op_e   = op_e'(cmd_op);
    assign unused_led = ^led[6:KEY_W];

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_status = status_q;
    assign rsp_found  = found_q;
    assign rsp_key    = rkey_q;
    assign rsp_count  = count_q;
    assign sw         = sw_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        key_d    = key_q;
        sw_d     = sw_q;
        probe_d  = probe_q;
        status_d = status_q;
        found_d  = found_q;
        rkey_d   = rkey_q;
        count_d  = count_q;
        k0       = 1'b0;
        k1       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op_e;
                    key_d    = cmd_key;
                    found_d  = 1'b0;
                    rkey_d   = cmd_key;
                    count_d  = tree_counter;
                    probe_d  = 1'b0;
                    status_d = ST_OK;
                    state_d  = S_RESP;
                    if (cmd_op_e == OP_RSVD) begin
                        status_d = ST_BAD;
                    end else if (cmd_op_e == OP_INSERT && buf_full) begin
                        status_d = ST_FULL;
                    end else if (cmd_op_e == OP_INSERT && cmd_key == '0) begin
                        status_d = ST_BAD;
                    end else if (cmd_op_e == OP_FIND && buf_empty) begin
                        status_d = ST_EMPTY;
                    end else begin
                        state_d = S_ISSUE;
                        sw_d    = (cmd_op_e == OP_CLEAR) ? '0 : cmd_key;
`ifdef TREE_DRV_DUP_CHECK_EN
                        probe_d = (cmd_op_e == OP_INSERT) && !buf_empty;
`endif
                    end
                end
            end
            S_ISSUE: begin
                // The duplicate probe reuses ISSUE/WAIT as a FIND before the real insert.
                k0      = (op_q == OP_FIND) || probe_q;
                k1      = !((op_q == OP_FIND) || probe_q);
                cnt_d   = CNT_W'(RESP_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    count_d = tree_counter;
                    state_d = S_RESP;
                    if (probe_q) begin
                        probe_d = 1'b0;
                        if (led[7]) begin
                            status_d = ST_BAD;
                            found_d  = 1'b1;
                        end else begin
                            cnt_d   = CNT_W'(GAP - 1);
                            state_d = S_PGAP;
                        end
                    end else if (op_q == OP_FIND) begin
                        found_d = led[7];
                        rkey_d  = led[KEY_W-1:0];
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = CNT_W'(GAP - 1);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_PGAP: begin
                if (cnt_q == '0) state_d = S_ISSUE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset lands in GAP with a zero count so cmd_ready rises on the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_GAP;
            cnt_q    <= '0;
            op_q     <= OP_FIND;
            key_q    <= '0;
            sw_q     <= '0;
            probe_q  <= 1'b0;
            status_q <= ST_OK;
            found_q  <= 1'b0;
            rkey_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            key_q    <= key_d;
            sw_q     <= sw_d;
            probe_q  <= probe_d;
            status_q <= status_d;
            found_q  <= found_d;
            rkey_q   <= rkey_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_tree_cmd_driver.sv
// Self-checking bench for tree_cmd_driver against a behavioural Tree and per-command expectations.
module tb_tree_cmd_driver;
    import tree_drv_pkg::*;

    localparam int unsigned KW = 4;
    localparam int unsigned RL = 2;
    localparam int unsigned GP = 2;
    localparam int unsigned CAP = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          rsp_ready = 1'b0;
    logic [1:0]    cmd_op = 2'b00;
    logic [KW-1:0] cmd_key = '0;
    logic          cmd_ready, rsp_valid, rsp_found, k0, k1;
    logic [1:0]    rsp_status;
    logic [KW-1:0] rsp_key, sw;
    logic [2:0]    rsp_count;
    logic [7:0]    led = '0;
    logic          buf_full = 1'b0;
    logic          buf_empty = 1'b1;
    logic [2:0]    tree_counter = '0;

    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    tree_cmd_driver #(.KEY_W(KW), .RESP_LAT(RL), .GAP(GP)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_found(rsp_found), .rsp_key(rsp_key), .rsp_count(rsp_count),
        .k0(k0), .k1(k1), .sw(sw), .led(led),
        .buf_full(buf_full), .buf_empty(buf_empty), .tree_counter(tree_counter)
    );

    // Behavioural Tree: a key set of capacity CAP, results registered one clock after a pulse.
    bit          present [16];
    int unsigned occ = 0;
    always @(posedge clk) begin
        if (k1) begin
            if (sw == '0) begin
                foreach (present[i]) present[i] = 1'b0;
                occ = 0;
            end else if (!present[sw] && occ < CAP) begin
                present[sw] = 1'b1;
                occ++;
            end
        end
        if (k0) led <= present[sw] ? {1'b1, 3'b000, sw} : 8'h00;
        tree_counter <= 3'(occ);
        buf_full     <= (occ == CAP);
        buf_empty    <= (occ == 0);
    end

    int unsigned   n_k0 = 0, n_k1 = 0, n_both = 0;
    logic [KW-1:0] sw_at_k0 = '0, sw_at_k1 = '0;
    always @(posedge clk) begin
        if (k0) begin n_k0++; sw_at_k0 = sw; end
        if (k1) begin n_k1++; sw_at_k1 = sw; end
        if (k0 && k1) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [KW-1:0] key, input int unsigned hold);
        logic [1:0]    e_st;
        logic          e_found;
        logic [KW-1:0] e_key;
        logic [2:0]    e_cnt;
        int unsigned   e_lat, e_k0, e_k1, occ0, b0, b1, lat, w;
        bit            hit;
        cmd_op    = op;
        cmd_key   = key;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
        check("accept_wait", cmd_ready, 1);
        occ0 = occ;
        hit  = (key != '0) && present[key];
        b0   = n_k0;
        b1   = n_k1;

        e_st = ST_OK; e_found = 1'b0; e_key = key; e_cnt = 3'(occ0);
        e_k0 = 0; e_k1 = 0; e_lat = 1;
        if (op == 2'b11) e_st = ST_BAD;
        else if (op == OP_INSERT && occ0 == CAP) e_st = ST_FULL;
        else if (op == OP_INSERT && key == '0) e_st = ST_BAD;
        else if (op == OP_FIND && occ0 == 0) e_st = ST_EMPTY;
        else if (op == OP_FIND) begin
            e_k0 = 1; e_lat = RL + 2; e_found = hit; e_key = hit ? key : '0;
        end else if (op == OP_CLEAR) begin
            e_k1 = 1; e_lat = RL + 2; e_cnt = '0;
        end else begin
`ifdef TREE_DRV_DUP_CHECK_EN
            if (occ0 != 0 && hit) begin
                e_k0 = 1; e_lat = RL + 2; e_st = ST_BAD; e_found = 1'b1;
            end else if (occ0 != 0) begin
                e_k0 = 1; e_k1 = 1; e_lat = 2 * RL + GP + 3; e_cnt = 3'(occ0 + 1);
            end else begin
                e_k1 = 1; e_lat = RL + 2; e_cnt = 3'(occ0 + 1);
            end
`else
            e_k1 = 1; e_lat = RL + 2; e_cnt = hit ? 3'(occ0) : 3'(occ0 + 1);
`endif
        end

        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check("rsp_latency", lat, e_lat);
        check("rsp_status", rsp_status, e_st);
        check("rsp_found", rsp_found, e_found);
        check("rsp_key", rsp_key, e_key);
        check("rsp_count", rsp_count, e_cnt);
        for (int i = 0; i < int'(hold); i++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_rsp", {rsp_status, rsp_found, rsp_key, rsp_count}, {e_st, e_found, e_key, e_cnt});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        w = 0;
        while (!cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
        check("gap_cycles", w, GP);
        check("k0_pulses", n_k0 - b0, e_k0);
        check("k1_pulses", n_k1 - b1, e_k1);
        if (e_k0 != 0) check("sw_at_k0", sw_at_k0, key);
        if (e_k1 != 0) check("sw_at_k1", sw_at_k1, (op == OP_CLEAR) ? '0 : key);
    endtask

    initial begin
        int unsigned r;
        logic [1:0]  rop;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {cmd_ready, rsp_valid, k0, k1, sw, rsp_status, rsp_found, rsp_key, rsp_count}, 0);
        rst_n = 1'b1;
        #1;
        check("ready_before_clk", cmd_ready, 0);
        @(posedge clk); #1;
        check("ready_after_clk", cmd_ready, 1);

        run_cmd(OP_INSERT, 4'd5, 0);
        run_cmd(OP_FIND, 4'd5, 0);
        run_cmd(OP_FIND, 4'd6, 0);
        run_cmd(OP_CLEAR, 4'd7, 0);
        run_cmd(OP_CLEAR, 4'd3, 0);
        run_cmd(OP_FIND, 4'd9, 0);
        run_cmd(OP_INSERT, 4'd0, 0);
        run_cmd(2'b11, 4'd4, 0);
        for (int k = 1; k <= 7; k++) run_cmd(OP_INSERT, 4'(k), 0);
        run_cmd(OP_INSERT, 4'd15, 0);
        run_cmd(OP_FIND, 4'd3, 5);
        run_cmd(OP_CLEAR, 4'd0, 0);
        run_cmd(OP_INSERT, 4'd5, 0);
        run_cmd(OP_INSERT, 4'd5, 1);

        // Reset asserted while the FIND is waiting for led.
        cmd_op = OP_FIND; cmd_key = 4'd5; cmd_valid = 1'b1;
        r = 0;
        while (!cmd_ready && r < 50) begin @(posedge clk); #1; r++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {k0, k1, rsp_valid, cmd_ready}, 0);
        @(posedge clk); #1;
        check("rst_mid_held", {k0, k1, rsp_valid, cmd_ready}, 0);
        rst_n = 1'b1;
        run_cmd(OP_FIND, 4'd5, 0);

        repeat (60) begin
            r = $urandom_range(0, 11);
            if (r <= 5)       rop = OP_INSERT;
            else if (r <= 9)  rop = OP_FIND;
            else if (r == 10) rop = OP_CLEAR;
            else              rop = 2'b11;
            run_cmd(rop, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        check("k0_k1_exclusive", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
